// File: rtl/lut_cfg_loader.sv
// Streaming loader that packs a valid/ready word stream into the LUT bank shadow
// register, then issues a single-cycle commit with the in_weights bus select.
module lut_cfg_loader #(
    parameter int unsigned NUM_LUTS  = 16,
    parameter int unsigned LUT_DEPTH = 16,
    parameter int unsigned LUT_WIDTH = 4,
    parameter int unsigned IN_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_last,
    output logic [4095:0]       cfg_data,
    output logic                bus_sel,
    output logic                cfg_update,
    output logic                lut_wr_valid,
    output logic                busy,
    output logic                load_done,
    output logic                err
);

    localparam int unsigned OUT_BITS  = 4096;
    localparam int unsigned CFG_BITS  = NUM_LUTS * LUT_DEPTH * LUT_WIDTH;
    localparam int unsigned NUM_WORDS = CFG_BITS / IN_WIDTH;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned IDX_W     = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 err_next;
    logic                 wr_en;
    logic                 commit_next;
    logic                 done_next;
    logic                 busy_next;
    logic [CFG_BITS-1:0]  cfg_q;
    logic [IDX_W-1:0]     wr_base;

    assign s_ready  = (state == LOAD);
    assign cfg_data = OUT_BITS'(cfg_q);
    assign wr_base  = IDX_W'(cnt) * IDX_W'(IN_WIDTH);

    // Next-state, counter and framing-error decode; strobes follow the next state
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = err;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (s_valid) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                        if (s_last) begin
                            state_next = COMMIT;
                        end else begin
                            state_next = IDLE;
                            err_next   = 1'b1;
                        end
                    end else if (s_last) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            COMMIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        commit_next = (state_next == COMMIT);
        done_next   = (state_next == DONE);
        busy_next   = (state_next != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            bus_sel      <= 1'b0;
            cfg_update   <= 1'b0;
            lut_wr_valid <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            err          <= err_next;
            busy         <= busy_next;
            bus_sel      <= commit_next;
            cfg_update   <= commit_next;
            lut_wr_valid <= commit_next;
            load_done    <= done_next;
        end
    end

    // Shadow register; untouched outside accepted words so it holds through COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (wr_en) begin
            cfg_q[wr_base +: IN_WIDTH] <= s_data;
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized self-checking bench for lut_cfg_loader against a word-array model
// of the shadow register and the load framing rules.
module tb_lut_cfg_loader;

    localparam int NW = 32;
    localparam int NO_LAST  = 1000;
    localparam int NO_ABORT = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, s_valid, s_last;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [4095:0] cfg_data;
    logic          bus_sel, cfg_update, lut_wr_valid, busy, load_done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_upd = 0, n_wr = 0, n_done = 0;

    logic [1023:0] exp_cfg;
    logic          exp_err;

    lut_cfg_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cfg_data(cfg_data), .bus_sel(bus_sel), .cfg_update(cfg_update),
        .lut_wr_valid(lut_wr_valid), .busy(busy), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_update === 1'b1)   n_upd++;
        if (lut_wr_valid === 1'b1) n_wr++;
        if (load_done === 1'b1)    n_done++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_cfg(input string tag);
        logic [4095:0] expv;
        expv = {3072'b0, exp_cfg};
        checks++;
        assert (cfg_data === expv) else begin
            errors++;
            $error("FAIL %s: cfg_data low word %0h upper-zero %0b, expected low word %0h",
                   tag, cfg_data[31:0], (cfg_data[4095:1024] == '0), expv[31:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load: words 0..NW-1, s_last on last_at, abort with word abort_at
    task automatic do_load(input int last_at, input int abort_at, input int max_gap,
                           input bit pat, input bit start_mid);
        int start_cyc, u0, w0, d0, outcome;
        logic [31:0] word;
        bit stop;
        u0 = n_upd; w0 = n_wr; d0 = n_done;
        outcome = 0;  // 0 commit, 1 framing error, 2 aborted
        stop = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        exp_err = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_by_start", 32'(err), 32'd0);
        for (int k = 0; k < NW && !stop; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'($urandom);
                start   = start_mid;
                tick();
            end
            chk("s_ready_in_load", 32'(s_ready), 32'd1);
            word    = pat ? {8{4'(k)}} : 32'($urandom);
            s_valid = 1'b1;
            s_data  = word;
            s_last  = (k == last_at);
            abort   = (k == abort_at);
            start   = start_mid;
            tick();
            s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; start = 1'b0;
            if (k == abort_at) begin
                outcome = 2; stop = 1;
            end else begin
                exp_cfg[k*32 +: 32] = word;
                if (k == NW - 1) begin
                    outcome = (last_at == NW - 1) ? 0 : 1;
                    stop = 1;
                end else if (k == last_at) begin
                    outcome = 1; stop = 1;
                end
            end
        end
        if (outcome == 1) exp_err = 1'b1;
        if (outcome == 0) begin
            chk("commit_cfg_update", 32'(cfg_update), 32'd1);
            chk("commit_lut_wr_valid", 32'(lut_wr_valid), 32'd1);
            chk("commit_bus_sel", 32'(bus_sel), 32'd1);
            chk("commit_s_ready", 32'(s_ready), 32'd0);
            chk_cfg("cfg_in_commit");
            if (max_gap == 0) chk("commit_latency", 32'(cyc - start_cyc), 32'(NW));
            tick();
            chk("done_pulse", 32'(load_done), 32'd1);
            chk("done_bus_sel", 32'(bus_sel), 32'd0);
            chk("done_cfg_update", 32'(cfg_update), 32'd0);
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
        end else begin
            chk("busy_after_fail", 32'(busy), 32'd0);
            chk("s_ready_after_fail", 32'(s_ready), 32'd0);
            tick();
            tick();
        end
        chk("err_flag", 32'(err), 32'(exp_err));
        chk_cfg("cfg_after_load");
        chk("update_count", 32'(n_upd - u0), (outcome == 0) ? 32'd1 : 32'd0);
        chk("wr_valid_count", 32'(n_wr - w0), (outcome == 0) ? 32'd1 : 32'd0);
        chk("done_count", 32'(n_done - d0), (outcome == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        exp_cfg = '0; exp_err = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_cfg_update", 32'(cfg_update), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_cfg("rst_cfg");
        rst_n = 1'b1;
        tick();

        do_load(NW - 1, NO_ABORT, 0, 1'b1, 1'b0);   // full load, back-to-back
        do_load(NW - 1, NO_ABORT, 3, 1'b0, 1'b0);   // random data with gaps
        do_load(NW - 1, NO_ABORT, 3, 1'b1, 1'b0);   // pattern with gaps
        do_load(5, NO_ABORT, 1, 1'b0, 1'b0);        // early s_last
        do_load(NW - 1, NO_ABORT, 1, 1'b1, 1'b0);   // recovery load
        do_load(NO_LAST, NO_ABORT, 0, 1'b0, 1'b0);  // missing s_last
        do_load(NW - 1, NO_ABORT, 0, 1'b1, 1'b0);
        do_load(NW - 1, 10, 2, 1'b0, 1'b1);         // abort at word 10, start mid-load

        // Async reset in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cfg = '0;
        chk_cfg("midload_rst_cfg");
        chk("midload_rst_busy", 32'(busy), 32'd0);
        chk("midload_rst_update", 32'(cfg_update), 32'd0);
        chk("midload_rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("midload_rst_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_load(NW - 1, NO_ABORT, 0, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            do_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : NW - 1,
                    NO_ABORT, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
